// File: rtl/timestamp_pkg.sv
// Shared constants, frame layout and state encoding for the
// timestamp UART sequencer.
package timestamp_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Byte positions inside one frame: "MM-DD HH:mm:SS\r\n"
    localparam logic [3:0] POS_M1  = 4'd0;
    localparam logic [3:0] POS_M0  = 4'd1;
    localparam logic [3:0] POS_SD  = 4'd2;
    localparam logic [3:0] POS_D1  = 4'd3;
    localparam logic [3:0] POS_D0  = 4'd4;
    localparam logic [3:0] POS_SP  = 4'd5;
    localparam logic [3:0] POS_H1  = 4'd6;
    localparam logic [3:0] POS_H0  = 4'd7;
    localparam logic [3:0] POS_ST1 = 4'd8;
    localparam logic [3:0] POS_N1  = 4'd9;
    localparam logic [3:0] POS_N0  = 4'd10;
    localparam logic [3:0] POS_ST2 = 4'd11;
    localparam logic [3:0] POS_S1  = 4'd12;
    localparam logic [3:0] POS_S0  = 4'd13;
    localparam logic [3:0] POS_CR  = 4'd14;
    localparam logic [3:0] POS_LF  = 4'd15;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/bin2ascii2.sv
// Converts a 6-bit binary value (0-63) into two ASCII decimal digits.
// Purely combinational.
module bin2ascii2
    import timestamp_pkg::*;
(
    input  logic [5:0] bin,
    output logic [7:0] tens,
    output logic [7:0] units
);

    logic [5:0] tens_val;
    logic [5:0] units_val;

    assign tens_val  = bin / 6'd10;
    assign units_val = bin % 6'd10;

    assign tens  = ASCII_ZERO + {2'b00, tens_val};
    assign units = ASCII_ZERO + {2'b00, units_val};

endmodule

// File: rtl/timestamp_uart_sequencer.sv
// Snapshots the time fields on start and streams one ASCII timestamp
// frame into the UART transmitter over a valid/ready handshake.
module timestamp_uart_sequencer
    import timestamp_pkg::*;
#(
    parameter logic [7:0] SEP_DATE = 8'h2D,
    parameter logic [7:0] SEP_TIME = 8'h3A,
    parameter bit         EN_CRLF  = 1'b1
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    input  logic [4:0] days,
    input  logic [3:0] months,
    input  logic       tx_ready,
    input  logic       clear_overrun,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       overrun
);

    localparam logic [3:0] LAST_IDX = EN_CRLF ? POS_LF : POS_S0;

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic       load;
    logic       set_ovr;
    logic       overrun_q, overrun_d;

    logic [5:0] sec_q, min_q;
    logic [4:0] hr_q, day_q;
    logic [3:0] mon_q;

    logic [7:0] mo1, mo0, dy1, dy0, hr1, hr0, mi1, mi0, se1, se0;
    logic [7:0] frame_byte;

    bin2ascii2 u_mon (.bin({2'b00, mon_q}), .tens(mo1), .units(mo0));
    bin2ascii2 u_day (.bin({1'b0, day_q}),  .tens(dy1), .units(dy0));
    bin2ascii2 u_hr  (.bin({1'b0, hr_q}),   .tens(hr1), .units(hr0));
    bin2ascii2 u_min (.bin(min_q),          .tens(mi1), .units(mi0));
    bin2ascii2 u_sec (.bin(sec_q),          .tens(se1), .units(se0));

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            overrun_q <= 1'b0;
            sec_q     <= 6'd0;
            min_q     <= 6'd0;
            hr_q      <= 5'd0;
            day_q     <= 5'd0;
            mon_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            if (load) begin
                sec_q <= seconds;
                min_q <= minutes;
                hr_q  <= hours;
                day_q <= days;
                mon_q <= months;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        set_ovr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    idx_d   = 4'd0;
                    load    = 1'b1;
                end
            end
            SEND: begin
                set_ovr = start;
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new overrun wins over a simultaneous clear request
    always_comb begin
        overrun_d = overrun_q;
        if (set_ovr)
            overrun_d = 1'b1;
        else if (clear_overrun)
            overrun_d = 1'b0;
    end

    always_comb begin
        frame_byte = 8'h00;
        case (idx_q)
            POS_M1:  frame_byte = mo1;
            POS_M0:  frame_byte = mo0;
            POS_SD:  frame_byte = SEP_DATE;
            POS_D1:  frame_byte = dy1;
            POS_D0:  frame_byte = dy0;
            POS_SP:  frame_byte = ASCII_SPACE;
            POS_H1:  frame_byte = hr1;
            POS_H0:  frame_byte = hr0;
            POS_ST1: frame_byte = SEP_TIME;
            POS_N1:  frame_byte = mi1;
            POS_N0:  frame_byte = mi0;
            POS_ST2: frame_byte = SEP_TIME;
            POS_S1:  frame_byte = se1;
            POS_S0:  frame_byte = se0;
            POS_CR:  frame_byte = EN_CRLF ? ASCII_CR : 8'h00;
            POS_LF:  frame_byte = EN_CRLF ? ASCII_LF : 8'h00;
            default: frame_byte = 8'h00;
        endcase
    end

    assign tx_valid = (state_q == SEND);
    assign busy     = (state_q == SEND);
    assign tx_data  = tx_valid ? frame_byte : 8'h00;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_timestamp_uart_sequencer.sv
// Directed and randomized checks of timestamp_uart_sequencer against
// a frame-level reference model.
module tb_timestamp_uart_sequencer;

    logic       CLK = 1'b0;
    logic       reset;
    logic       start, start2;
    logic [5:0] seconds, minutes;
    logic [4:0] hours, days;
    logic [3:0] months;
    logic       tx_ready, tx_ready2;
    logic       clear_overrun;
    logic [7:0] tx_data, tx_data2;
    logic       tx_valid, tx_valid2;
    logic       busy, busy2;
    logic       overrun, overrun2;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];

    always #5 CLK = ~CLK;

    timestamp_uart_sequencer dut (
        .CLK(CLK), .reset(reset), .start(start),
        .seconds(seconds), .minutes(minutes), .hours(hours),
        .days(days), .months(months),
        .tx_ready(tx_ready), .clear_overrun(clear_overrun),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .busy(busy), .overrun(overrun)
    );

    timestamp_uart_sequencer #(.EN_CRLF(1'b0)) dut2 (
        .CLK(CLK), .reset(reset), .start(start2),
        .seconds(seconds), .minutes(minutes), .hours(hours),
        .days(days), .months(months),
        .tx_ready(tx_ready2), .clear_overrun(clear_overrun),
        .tx_data(tx_data2), .tx_valid(tx_valid2),
        .busy(busy2), .overrun(overrun2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dig(input int v, input bit tens);
        return 8'(tens ? 48 + v / 10 : 48 + v % 10);
    endfunction

    task automatic build(input int mo, input int dd, input int hh,
                         input int mi, input int ss, input bit crlf);
        exp_q.delete();
        exp_q.push_back(dig(mo, 1)); exp_q.push_back(dig(mo, 0));
        exp_q.push_back(8'h2D);
        exp_q.push_back(dig(dd, 1)); exp_q.push_back(dig(dd, 0));
        exp_q.push_back(8'h20);
        exp_q.push_back(dig(hh, 1)); exp_q.push_back(dig(hh, 0));
        exp_q.push_back(8'h3A);
        exp_q.push_back(dig(mi, 1)); exp_q.push_back(dig(mi, 0));
        exp_q.push_back(8'h3A);
        exp_q.push_back(dig(ss, 1)); exp_q.push_back(dig(ss, 0));
        if (crlf) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic set_fields(input int mo, input int dd, input int hh,
                              input int mi, input int ss);
        months  = 4'(mo);
        days    = 5'(dd);
        hours   = 5'(hh);
        minutes = 6'(mi);
        seconds = 6'(ss);
    endtask

    // Called at #1 after an edge; returns at #1 after the start edge
    task automatic pulse_start(input string tag, input bit sel);
        if (sel) start2 = 1'b1; else start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0; start2 = 1'b0;
        chk({tag, " latency valid"}, sel ? tx_valid2 : tx_valid, 1);
        chk({tag, " latency busy"}, sel ? busy2 : busy, 1);
        chk({tag, " first byte"}, sel ? tx_data2 : tx_data, exp_q[0]);
    endtask

    // mode: 0 always ready, 1 pattern 1,0,0,1, 2 random
    task automatic collect(input string tag, input bit sel, input int mode,
                           input int inj_at, input bit inj_clr);
        int idx = 0;
        int cyc = 0;
        bit r;
        bit injected = 0;
        bit stalled = 0;
        logic [7:0] prev = 8'h00;
        logic [7:0] d;
        while (idx < exp_q.size() && cyc < 400) begin
            case (mode)
                0: r = 1'b1;
                1: r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            tx_ready = r; tx_ready2 = r;
            if (!injected && idx == inj_at) begin
                injected = 1;
                if (sel) start2 = 1'b1; else start = 1'b1;
                clear_overrun = inj_clr;
            end
            d = sel ? tx_data2 : tx_data;
            chk({tag, " valid"}, sel ? tx_valid2 : tx_valid, 1);
            if (stalled) chk({tag, " hold"}, d, prev);
            @(posedge CLK); #1;
            start = 1'b0; start2 = 1'b0; clear_overrun = 1'b0;
            if (r) begin
                chk({tag, " byte"}, d, exp_q[idx]);
                idx++;
                stalled = 0;
            end else begin
                stalled = 1;
                prev = d;
            end
            cyc++;
        end
        chk({tag, " count"}, idx, exp_q.size());
        chk({tag, " end valid"}, sel ? tx_valid2 : tx_valid, 0);
        chk({tag, " end busy"}, sel ? busy2 : busy, 0);
        tx_ready = 1'b1; tx_ready2 = 1'b1;
    endtask

    task automatic clear_ovr();
        clear_overrun = 1'b1;
        @(posedge CLK); #1;
        clear_overrun = 1'b0;
        chk("overrun cleared", overrun, 0);
    endtask

    initial begin
        int mo, dd, hh, mi, ss;
        reset = 1'b1;
        start = 1'b0; start2 = 1'b0;
        tx_ready = 1'b0; tx_ready2 = 1'b0;
        clear_overrun = 1'b0;
        set_fields(0, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        #1;
        chk("reset valid", tx_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset data", tx_data, 8'h00);
        chk("reset overrun", overrun, 0);
        chk("reset2 valid", tx_valid2, 0);
        chk("reset2 data", tx_data2, 8'h00);
        reset = 1'b0;
        @(posedge CLK); #1;

        // Basic frame with continuous ready
        set_fields(3, 7, 9, 5, 42);
        build(3, 7, 9, 5, 42, 1);
        tx_ready = 1'b1;
        pulse_start("basic", 0);
        collect("basic", 0, 0, -1, 0);

        // Stalls with ready pattern 1,0,0,1
        pulse_start("stall", 0);
        collect("stall", 0, 1, -1, 0);

        // Inputs change after start; frame keeps the snapshot
        pulse_start("snap", 0);
        set_fields(12, 31, 23, 59, 59);
        collect("snap", 0, 1, -1, 0);
        build(12, 31, 23, 59, 59, 1);
        pulse_start("snap2", 0);
        collect("snap2", 0, 0, -1, 0);

        // Overrun behaviour
        chk("overrun idle", overrun, 0);
        pulse_start("ovr5", 0);
        collect("ovr5", 0, 0, 5, 0);
        chk("overrun set", overrun, 1);
        repeat (3) @(posedge CLK);
        #1;
        chk("overrun sticky", overrun, 1);
        clear_ovr();
        pulse_start("ovrclr", 0);
        collect("ovrclr", 0, 0, 3, 1);
        chk("overrun set wins", overrun, 1);
        clear_ovr();
        pulse_start("ovrlast", 0);
        collect("ovrlast", 0, 0, 15, 0);
        chk("overrun last byte", overrun, 1);
        @(posedge CLK); #1;
        chk("last start dropped", busy, 0);
        clear_ovr();

        // Asynchronous reset mid-frame at byte 8
        set_fields(3, 7, 9, 5, 42);
        build(3, 7, 9, 5, 42, 1);
        pulse_start("rst", 0);
        repeat (8) @(posedge CLK);
        #1;
        chk("rst at byte 8", tx_data, exp_q[8]);
        #1 reset = 1'b1;
        #1;
        chk("rst async valid", tx_valid, 0);
        chk("rst async busy", busy, 0);
        chk("rst async data", tx_data, 8'h00);
        #2 reset = 1'b0;
        @(posedge CLK); #1;
        chk("rst idle", busy, 0);
        pulse_start("after rst", 0);
        collect("after rst", 0, 0, -1, 0);

        // Randomized fields, ready and input churn
        for (int k = 0; k < 8; k++) begin
            mo = int'($urandom_range(0, 15));
            dd = int'($urandom_range(0, 31));
            hh = int'($urandom_range(0, 31));
            mi = int'($urandom_range(0, 63));
            ss = int'($urandom_range(0, 63));
            set_fields(mo, dd, hh, mi, ss);
            build(mo, dd, hh, mi, ss, 1);
            pulse_start("rand", 0);
            set_fields(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                       int'($urandom_range(0, 63)));
            collect("rand", 0, 2, -1, 0);
        end

        // No CR/LF variant, out-of-range seconds
        set_fields(5, 9, 0, 0, 63);
        build(5, 9, 0, 0, 63, 0);
        tx_ready2 = 1'b1;
        pulse_start("nocrlf", 1);
        collect("nocrlf", 1, 0, -1, 0);
        chk("nocrlf overrun", overrun2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
